// File: rtl/mem_pkg.sv
// Shared definitions for the unified instruction/data memory:
// access-size encodings, arbiter FSM states and byte-lane constants.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_D = 2'd1,
        RESP_I = 2'd2
    } state_t;

    // Number of bytes touched by an access; the reserved code 11 acts as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load alignment and extension: picks the addressed byte/half/word
// out of a lane-ordered 32-bit word and sign/zero-extends it.
// Ports: raw (lane-ordered word), size, sgn, off (addr[1:0]), data.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  off,
    output logic [31:0] data
);

    logic [4:0]  sh;
    logic [31:0] rot;

    // Rotate so the byte at lane 'off' lands in bits [7:0]; a rotate
    // (not a shift) keeps wrapped bytes of a misaligned access in order.
    always_comb begin
        sh  = {off, 3'b000};
        rot = (raw >> sh) | (raw << (6'd32 - {1'b0, sh}));
    end

    always_comb begin
        data = rot;
        case (size)
            SIZE_B:  data = {{24{sgn & rot[7]}}, rot[7:0]};
            SIZE_H:  data = {{16{sgn & rot[15]}}, rot[15:0]};
            default: data = rot;
        endcase
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-ported byte-addressable unified I/D memory with a fetch/data
// arbiter. Data wins ties; a port is never granted twice in a row.
// Ports: clk, rst (async active-low); fetch: if_req, if_addr,
// if_ready, if_data; data: d_req, d_we, d_size, d_signed, d_addr,
// d_wdata, d_ready, d_rdata; stall (combinational), misalign.
// Option: define MEM_MISALIGN_TRAP_EN to suppress misaligned accesses
// and flag them on misalign; otherwise they run byte-wise and misalign=0.
module unified_mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              stall,
    output logic              misalign
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [BYTE_W-1:0] mem [DEPTH];

    state_t state_q;
    state_t state_d;
    logic   grant_d;
    logic   grant_i;

    logic [31:0]       d_raw;
    logic [31:0]       i_raw;
    logic [31:0]       d_ext;
    logic [ADDR_W-1:0] da;
    logic [2:0]        d_bytes;
    logic              d_mis;
    logic              i_mis;

    logic [31:0] if_data_q;
    logic [31:0] d_rdata_q;
    logic        misalign_q;

    // A port in its own RESP cycle is finishing, so its request is
    // ignored there; this forces D/I interleaving under contention.
    always_comb begin
        state_d = IDLE;
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (d_req && state_q != RESP_D) begin
            state_d = RESP_D;
            grant_d = 1'b1;
        end else if (if_req && state_q != RESP_I) begin
            state_d = RESP_I;
            grant_i = 1'b1;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        d_mis = 1'b0;
        case (d_size)
            SIZE_B:  d_mis = 1'b0;
            SIZE_H:  d_mis = d_addr[0];
            default: d_mis = (d_addr[1:0] != 2'b00);
        endcase
    end
    assign i_mis = (if_addr[1:0] != 2'b00);
`else
    assign d_mis = 1'b0;
    assign i_mis = 1'b0;
`endif

    assign d_bytes = size_bytes(d_size);

    // Data bytes are placed in the lane given by their own address, so
    // aligned accesses see the natural word and misaligned ones a
    // rotated window that mem_load_ext undoes. Fetch is lane k = a+k.
    always_comb begin
        d_raw = '0;
        i_raw = '0;
        da    = '0;
        for (int k = 0; k < LANES; k++) begin
            da = d_addr + ADDR_W'(k);
            d_raw[{da[1:0], 3'b000} +: BYTE_W] = mem[da];
            i_raw[k*BYTE_W +: BYTE_W] = mem[if_addr + ADDR_W'(k)];
        end
    end

    mem_load_ext u_load_ext (
        .raw  (d_raw),
        .size (d_size),
        .sgn  (d_signed),
        .off  (d_addr[1:0]),
        .data (d_ext)
    );

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (grant_d && d_we && !d_mis) begin
            for (int k = 0; k < LANES; k++) begin
                if (3'(k) < d_bytes) begin
                    mem[d_addr + ADDR_W'(k)] <= d_wdata[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            if_data_q  <= '0;
            d_rdata_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= (grant_d & d_mis) | (grant_i & i_mis);
            if (grant_d) begin
                d_rdata_q <= (d_we || d_mis) ? 32'd0 : d_ext;
            end
            if (grant_i) begin
                if_data_q <= i_mis ? 32'd0 : i_raw;
            end
        end
    end

    assign if_ready = (state_q == RESP_I);
    assign d_ready  = (state_q == RESP_D);
    assign if_data  = if_data_q;
    assign d_rdata  = d_rdata_q;
    assign misalign = misalign_q;

    assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a response scoreboard:
// expected results are queued at request time and checked at ready.
module tb_unified_mem_arbiter;
    import mem_pkg::*;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [31:0]       if_data;
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic              d_signed;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ready;
    logic [31:0]       d_rdata;
    logic              stall;
    logic              misalign;

    int n_assert = 0;
    int n_fail   = 0;

    logic [32:0] d_q[$];
    logic [32:0] i_q[$];

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_data  (if_data),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_size   (d_size),
        .d_signed (d_signed),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .stall    (stall),
        .misalign (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Sample responses mid-cycle, then move to just after the next edge.
    task automatic tick();
        logic [32:0] e;
        @(negedge clk);
        if (d_ready) begin
            chk1("d_ready_expected", d_q.size() != 0, 1'b1);
            if (d_q.size() != 0) begin
                e = d_q.pop_front();
                chk("d_rdata", d_rdata, e[31:0]);
                chk1("d_misalign", misalign, e[32]);
            end
        end
        if (if_ready) begin
            chk1("if_ready_expected", i_q.size() != 0, 1'b1);
            if (i_q.size() != 0) begin
                e = i_q.pop_front();
                chk("if_data", if_data, e[31:0]);
                chk1("if_misalign", misalign, e[32]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic d_access(input logic we, input logic [1:0] sz,
                            input logic sg, input logic [7:0] a,
                            input logic [31:0] wd, input logic [31:0] exp,
                            input logic mis);
        int cyc = 0;
        d_req = 1'b1;
        d_we = we;
        d_size = sz;
        d_signed = sg;
        d_addr = a;
        d_wdata = wd;
        d_q.push_back({mis, exp});
        do begin
            tick();
            cyc++;
        end while (!d_ready && cyc < 8);
        chk("d_latency", 32'(cyc), 32'd1);
        d_req = 1'b0;
        tick();
    endtask

    task automatic i_access(input logic [7:0] a, input logic [31:0] exp,
                            input logic mis);
        int cyc = 0;
        if_req = 1'b1;
        if_addr = a;
        i_q.push_back({mis, exp});
        do begin
            tick();
            cyc++;
        end while (!if_ready && cyc < 8);
        chk("if_latency", 32'(cyc), 32'd1);
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_size = SIZE_W;
        d_signed = 1'b0;
        d_addr = '0;
        d_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk1("rst_if_ready", if_ready, 1'b0);
        chk1("rst_d_ready", d_ready, 1'b0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk1("rst_misalign", misalign, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b1;
        tick();

        d_access(1'b1, SIZE_W, 1'b0, 8'h00, 32'h00000013, 32'd0, 1'b0);
        d_access(1'b1, SIZE_W, 1'b0, 8'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        d_access(1'b0, SIZE_W, 1'b0, 8'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        d_access(1'b0, SIZE_B, 1'b1, 8'h13, 32'd0, 32'hFFFFFFDE, 1'b0);
        d_access(1'b0, SIZE_H, 1'b0, 8'h12, 32'd0, 32'h0000DEAD, 1'b0);
        d_access(1'b0, SIZE_H, 1'b1, 8'h12, 32'd0, 32'hFFFFDEAD, 1'b0);
        d_access(1'b0, SIZE_B, 1'b0, 8'h10, 32'd0, 32'h000000EF, 1'b0);
        d_access(1'b1, SIZE_B, 1'b0, 8'h11, 32'hFFFFFF7F, 32'd0, 1'b0);
        d_access(1'b0, SIZE_B, 1'b1, 8'h11, 32'd0, 32'h0000007F, 1'b0);
        d_access(1'b0, 2'b11, 1'b0, 8'h10, 32'd0, 32'hDEAD7FEF, 1'b0);
        d_access(1'b1, SIZE_H, 1'b0, 8'h14, 32'hAAAA8001, 32'd0, 1'b0);
        d_access(1'b0, SIZE_H, 1'b1, 8'h14, 32'd0, 32'hFFFF8001, 1'b0);
        i_access(8'h10, 32'hDEAD7FEF, 1'b0);

        // Both ports request from IDLE: data first, fetch one cycle later.
        d_req = 1'b1;
        d_we = 1'b0;
        d_size = SIZE_W;
        d_signed = 1'b0;
        d_addr = 8'h10;
        if_req = 1'b1;
        if_addr = 8'h00;
        d_q.push_back({1'b0, 32'hDEAD7FEF});
        i_q.push_back({1'b0, 32'h00000013});
        #1;
        chk1("cont_stall_n", stall, 1'b1);
        tick();
        chk1("cont_d_ready_n1", d_ready, 1'b1);
        chk1("cont_if_ready_n1", if_ready, 1'b0);
        chk1("cont_stall_n1", stall, 1'b1);
        d_req = 1'b0;
        tick();
        chk1("cont_if_ready_n2", if_ready, 1'b1);
        chk1("cont_d_ready_n2", d_ready, 1'b0);
        chk1("cont_stall_n2", stall, 1'b0);
        if_req = 1'b0;
        tick();

        // Both ports hold requests: responses must alternate D, I.
        d_req = 1'b1;
        if_req = 1'b1;
        for (int j = 0; j < 4; j++) begin
            d_q.push_back({1'b0, 32'hDEAD7FEF});
            i_q.push_back({1'b0, 32'h00000013});
        end
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk1("alt_d_ready", d_ready, (c % 2) == 1);
            chk1("alt_if_ready", if_ready, (c % 2) == 0);
        end
        d_req = 1'b0;
        if_req = 1'b0;
        tick();

        // Reset right after a store grant: store stays, response dropped.
        d_req = 1'b1;
        d_we = 1'b1;
        d_size = SIZE_W;
        d_addr = 8'h40;
        d_wdata = 32'hCAFEF00D;
        tick();
        rst = 1'b0;
        d_req = 1'b0;
        d_we = 1'b0;
        #1;
        chk1("mid_rst_d_ready", d_ready, 1'b0);
        chk1("mid_rst_if_ready", if_ready, 1'b0);
        chk("mid_rst_d_rdata", d_rdata, 32'd0);
        chk("mid_rst_if_data", if_data, 32'd0);
        chk1("mid_rst_misalign", misalign, 1'b0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        tick();
        tick();
        rst = 1'b1;
        tick();
        i_access(8'h00, 32'h00000013, 1'b0);
        d_access(1'b0, SIZE_W, 1'b0, 8'h40, 32'd0, 32'hCAFEF00D, 1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
        d_access(1'b1, SIZE_W, 1'b0, 8'h20, 32'hA5A5A5A5, 32'd0, 1'b0);
        d_access(1'b1, SIZE_W, 1'b0, 8'h21, 32'h12345678, 32'd0, 1'b1);
        d_access(1'b0, SIZE_W, 1'b0, 8'h20, 32'd0, 32'hA5A5A5A5, 1'b0);
        d_access(1'b0, SIZE_H, 1'b1, 8'h23, 32'd0, 32'd0, 1'b1);
        d_access(1'b0, SIZE_B, 1'b0, 8'h23, 32'd0, 32'h000000A5, 1'b0);
        i_access(8'h02, 32'd0, 1'b1);
`else
        d_access(1'b0, SIZE_H, 1'b0, 8'h13, 32'd0, 32'h000001DE, 1'b0);
        d_access(1'b1, SIZE_W, 1'b0, 8'hFE, 32'h11223344, 32'd0, 1'b0);
        d_access(1'b0, SIZE_B, 1'b0, 8'hFE, 32'd0, 32'h00000044, 1'b0);
        d_access(1'b0, SIZE_B, 1'b0, 8'hFF, 32'd0, 32'h00000033, 1'b0);
        d_access(1'b0, SIZE_B, 1'b0, 8'h00, 32'd0, 32'h00000022, 1'b0);
        d_access(1'b0, SIZE_B, 1'b0, 8'h01, 32'd0, 32'h00000011, 1'b0);
        d_access(1'b0, SIZE_W, 1'b0, 8'hFE, 32'd0, 32'h11223344, 1'b0);
        i_access(8'hFF, 32'h00112233, 1'b0);
`endif

        chk("d_queue_drained", 32'(d_q.size()), 32'd0);
        chk("i_queue_drained", 32'(i_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
